// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execution stage: single-cycle ALU ops plus serial one-bit-per-cycle shifts
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   typedef enum logic {IDLE, SHIFT} state_t;
   typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

   localparam logic [3:0] C_ADD  = 4'b1000;
   localparam logic [3:0] C_SUB  = 4'b1001;
   localparam logic [3:0] C_ADDU = 4'b0110;
   localparam logic [3:0] C_AND  = 4'b1100;
   localparam logic [3:0] C_OR   = 4'b0100;
   localparam logic [3:0] C_SLTU = 4'b1111;
   localparam logic [3:0] C_SLL  = 4'b1011;
   localparam logic [3:0] C_SRL  = 4'b1010;
   localparam logic [3:0] C_SRA  = 4'b0010;

   state_t           state_q, state_d;
   kind_t            kind_q, kind_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             is_shift;
   kind_t            kind_in;
   logic [WIDTH-1:0] sh_next;

   // Single-cycle datapath; unknown codes fall through to signed add
   always_comb begin
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] diff;
      sum      = a + b;
      diff     = a - b;
      alu_res  = sum;
      alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      is_shift = 1'b0;
      kind_in  = K_SLL;
      case (alu_ctrl)
         C_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         C_ADDU: alu_ovf = 1'b0;
         C_AND: begin
            alu_res = a & b;
            alu_ovf = 1'b0;
         end
         C_OR: begin
            alu_res = a | b;
            alu_ovf = 1'b0;
         end
         C_SLTU: begin
            alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            alu_ovf = 1'b0;
         end
         C_SLL: begin
            is_shift = 1'b1;
            kind_in  = K_SLL;
         end
         C_SRL: begin
            is_shift = 1'b1;
            kind_in  = K_SRL;
         end
         C_SRA: begin
            is_shift = 1'b1;
            kind_in  = K_SRA;
         end
         default: ;
      endcase
   end

   // One-position step of the serial shifter for the latched shift kind
   always_comb begin
      case (kind_q)
         K_SRL:   sh_next = {1'b0, sh_q[WIDTH-1:1]};
         K_SRA:   sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
         default: sh_next = {sh_q[WIDTH-2:0], 1'b0};
      endcase
   end

   // Next-state: issue in IDLE, count down in SHIFT, publish result on completion only
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (is_shift && (shamt != '0)) begin
                  sh_d    = b;
                  cnt_d   = shamt;
                  kind_d  = kind_in;
                  state_d = SHIFT;
               end else if (is_shift) begin
                  result_d = b;
                  zero_d   = (b == '0);
                  ovf_d    = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  ovf_d    = alu_ovf;
                  done_d   = 1'b1;
               end
            end
         end
         SHIFT: begin
            sh_d  = sh_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) begin
               result_d = sh_next;
               zero_d   = (sh_next == '0);
               ovf_d    = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         kind_q   <= K_SLL;
         sh_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed vector bench for alu_exec_unit
module tb_alu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  alu_ctrl;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
      .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
      .result(result), .zero(zero), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [31:0] res;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] c, input logic [31:0] va, input logic [31:0] vb,
                        input logic [4:0] s);
      alu_ctrl = c;
      a        = va;
      b        = vb;
      shamt    = s;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      int bcnt;
      @(negedge clk);
      drive(v.ctrl, v.a, v.b, v.shamt);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat  = 1;
      bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      check({v.name, " latency"}, lat, v.lat);
      check({v.name, " busy cycles"}, bcnt, v.lat - 1);
      check({v.name, " result"}, result, v.res);
      check({v.name, " zero"}, zero, (v.res == 32'd0));
      check({v.name, " overflow"}, overflow, v.ovf);
      check({v.name, " busy at done"}, busy, 1'b0);
      @(negedge clk);
      check({v.name, " done one pulse"}, done, 1'b0);
      check({v.name, " result held"}, result, v.res);
   endtask

   initial begin
      int lat;
      int dcnt;
      logic [31:0] res_at_done;

      vecs.push_back('{"add ovf",   4'b1000, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1, 1});
      vecs.push_back('{"sub zero",  4'b1001, 32'h5,        32'h5,        5'd0,  32'h0,        1'b0, 1});
      vecs.push_back('{"addu wrap", 4'b0110, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0, 1});
      vecs.push_back('{"sltu 1",    4'b1111, 32'h1,        32'hFFFFFFFF, 5'd0,  32'h1,        1'b0, 1});
      vecs.push_back('{"sltu 0",    4'b1111, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0, 1});
      vecs.push_back('{"unk add",   4'b0000, 32'h2,        32'h3,        5'd0,  32'h5,        1'b0, 1});
      vecs.push_back('{"unk ovf",   4'b0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0,  32'hFFFFFFFE, 1'b1, 1});
      vecs.push_back('{"add -1+1",  4'b1000, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0, 1});
      vecs.push_back('{"sub ovf",   4'b1001, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b1, 1});
      vecs.push_back('{"and",       4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1});
      vecs.push_back('{"or",        4'b0100, 32'h0F000000, 32'h000000F0, 5'd0,  32'h0F0000F0, 1'b0, 1});
      vecs.push_back('{"sra 31",    4'b0010, 32'h0,        32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 32});
      vecs.push_back('{"srl 31",    4'b1010, 32'h0,        32'h80000000, 5'd31, 32'h00000001, 1'b0, 32});
      vecs.push_back('{"sll 31",    4'b1011, 32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 32});
      vecs.push_back('{"sll 0",     4'b1011, 32'h7FFFFFFF, 32'h1234,     5'd0,  32'h00001234, 1'b0, 1});
      vecs.push_back('{"sra 4",     4'b0010, 32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, 5});
      vecs.push_back('{"srl 4",     4'b1010, 32'h0,        32'h000000F0, 5'd4,  32'h0000000F, 1'b0, 5});
      vecs.push_back('{"add ovf2",  4'b1000, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1, 1});
      vecs.push_back('{"sra 0 ovf", 4'b0010, 32'h7FFFFFFF, 32'h0,        5'd0,  32'h0,        1'b0, 1});

      rst_n = 1'b0;
      start = 1'b0;
      drive(4'b0, 32'h0, 32'h0, 5'd0);
      repeat (2) @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset result", result, 32'h0);
      check("reset zero", zero, 1'b1);
      check("reset overflow", overflow, 1'b0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-to-back: second start issued in the cycle the first done is high
      @(negedge clk);
      drive(4'b1001, 32'h5, 32'h5, 5'd0);
      start = 1'b1;
      @(negedge clk);
      check("b2b first done", done, 1'b1);
      check("b2b first result", result, 32'h0);
      drive(4'b1000, 32'h2, 32'h3, 5'd0);
      @(negedge clk);
      start = 1'b0;
      check("b2b second done", done, 1'b1);
      check("b2b second result", result, 32'h5);
      @(negedge clk);
      check("b2b done drops", done, 1'b0);

      // start during a shift is ignored; operands are not re-sampled
      @(negedge clk);
      drive(4'b1011, 32'h0, 32'h3, 5'd4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      drive(4'b1000, 32'h1, 32'h1, 5'd0);
      start = 1'b1;
      check("ign result unchanged mid-shift", result, 32'h5);
      @(negedge clk);
      start = 1'b0;
      lat  = 3;
      dcnt = 0;
      res_at_done = 32'hDEADBEEF;
      for (int k = 0; k < 12; k++) begin
         if (done) begin
            dcnt++;
            if (dcnt == 1) begin
               res_at_done = result;
               check("ign latency", lat, 5);
            end
         end
         @(negedge clk);
         lat++;
      end
      check("ign single done", dcnt, 1);
      check("ign result", res_at_done, 32'h30);

      // Reset mid-shift: immediate clear, no done afterwards
      @(negedge clk);
      drive(4'b1010, 32'h0, 32'hFFFFFFFF, 5'd10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("rst busy before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst result", result, 32'h0);
      check("rst zero", zero, 1'b1);
      check("rst overflow", overflow, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int k = 0; k < 15; k++) begin
         if (done || busy) dcnt++;
         @(negedge clk);
      end
      check("rst no done after release", dcnt, 0);
      run_vec('{"post-rst add", 4'b0000, 32'h2, 32'h3, 5'd0, 32'h5, 1'b0, 1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution stage directly downstream of the ALU-control decoder. Consumes the 4-bit ALU control code and the operands, and produces a registered result with zero and overflow flags.
- Shift operations (sll/srl/sra) run serially, one bit per cycle. This keeps the barrel shifter out of the critical path.
- All other operations complete in a single cycle.
- A start/busy/done handshake lets the multi-cycle datapath controller stall on shifts.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- alu_ctrl  input  4  ALU control code from the decoder
- a  input  WIDTH  operand rs
- b  input  WIDTH  operand rt; this is the shifted operand
- shamt  input  SHW  shift amount
- busy  output  1  high while a shift is in progress
- done  output  1  one-cycle pulse; result/flags valid
- result  output  WIDTH  registered result, held until the next completion
- zero  output  1  registered; equals (result == 0)
- overflow  output  1  registered signed overflow for add/sub; 0 otherwise

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, busy=0, done=0, result=0, zero=1, overflow=0, shift register=0, counter=0.
- Code map (alu_ctrl):
  - 1000 add: a+b signed; overflow = sign(a)==sign(b) && sign(res)!=sign(a).
  - 1001 sub: a-b; overflow = sign(a)!=sign(b) && sign(res)!=sign(a).
  - 0110 addu: a+b; overflow=0.
  - 1100 and; 0100 or.
  - 1111 sltu: result = {0…, (a<b unsigned)}.
  - 1011 sll: b<<shamt, zero fill.
  - 1010 srl: b>>shamt, zero fill.
  - 0010 sra: b>>>shamt, sign fill.
  - Any other code executes as add, including the overflow rule.
- States: IDLE, SHIFT.
- IDLE + start + non-shift code:
  - Compute and register result/zero/overflow at the sampling edge.
  - done=1 for exactly the next cycle.
  - Stay in IDLE. Latency 1.
- IDLE + start + shift code + shamt==0:
  - result=b, overflow=0. Latency 1, same as non-shift.
- IDLE + start + shift code + shamt=s>0, at edge 0:
  - Load shift register=b, counter=s, latch kind (sll/srl/sra).
  - busy=1; go to SHIFT.
- SHIFT, each edge:
  - Shift one position (sra replicates the MSB); counter--.
  - On the edge where the counter goes 1→0: write result and zero, overflow=0, done=1, busy=0, return to IDLE.
  - Total latency s+1 cycles; busy is high for s cycles.
- done is high only in the single cycle after completion. It is never high while busy is high.
- start while busy: ignored. Inputs are not re-sampled during SHIFT; operands are latched at edge 0.
- start is sampled in the same cycle done is high (state IDLE). It is accepted, allowing back-to-back issue.
- result/zero/overflow hold their last values until the next completion. They do not change at operation start.
- Reset asserted mid-shift: immediate return to reset values. No done pulse.
- All arithmetic is modulo 2^WIDTH; carries are discarded.

Test Plan:
- add a=0x7FFFFFFF, b=1, start 1 cycle → next cycle done=1, result=0x80000000, overflow=1, zero=0, busy never high.
- sub a=5, b=5 → result=0, zero=1, overflow=0. Then addu 0xFFFFFFFF+1 → result=0, overflow=0. Issue back-to-back → two consecutive done pulses.
- sltu a=1, b=0xFFFFFFFF → result=1. Then unknown code 0000 with a=2, b=3 → result=5 (add).
- sra b=0x80000000, shamt=31 → busy high 31 cycles, done on cycle 32, result=0xFFFFFFFF. srl same operands → result=0x00000001. sll b=1, shamt=31 → 0x80000000.
- sll shamt=0, b=0x1234 → latency 1, result=0x1234. During a shamt=4 shift, pulse start with a new add → ignored; result is the shift value and a single done.
- Assert rst_n=0 at cycle 3 of a shamt=10 shift → busy=0, done=0, result=0, zero=1 immediately. No done after release; a fresh op completes normally.
